sd_cmd_tx: RTL
==============

SD_CMD_TX -- requirements
Module: sd_cmd_tx

Interface
REQ-001 Parameter NCC, default 8, SHALL set the number of idle sd_clk cycles enforced after each end bit before the next command is accepted (range 1..255).
REQ-002 sd_clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 transmit_en  input  1  request; sampled only in IDLE.
REQ-005 cmd_index  input  6  command index; captured with transmit_en.
REQ-006 argument  input  32  command argument; captured with transmit_en.
REQ-007 sd_cmd_out  output  1  serial CMD-line data, MSB first.
REQ-008 sd_cmd_oe  output  1  CMD-line drive enable; line released when low.
REQ-009 busy  output  1  high from accept until the NCC gap ends.
REQ-010 sd_transmit_started  output  1  one-cycle pulse coincident with the start bit.
REQ-011 sd_transmit_finished  output  1  one-cycle pulse in the cycle after the end bit.

Function
REQ-012 Frame SHALL be 48 bits: start 0, transmission 1, cmd_index[5:0], argument[31:0], CRC7[6:0], end 1.
REQ-013 CRC7 SHALL use polynomial x^7+x^3+1, init 0, computed serially over the first 40 frame bits while they are shifted out; no precomputation.
REQ-014 States SHALL be IDLE, SEND (40 header/argument bits), CRC (7 bits), END (1 bit), GAP (NCC cycles).
REQ-015 IDLE->SEND when transmit_en=1 at a rising edge; cmd_index and argument SHALL be latched on that edge; later input changes SHALL not affect the frame.
REQ-016 All outputs SHALL be registered; the start bit appears on sd_cmd_out in the first cycle after the accepting edge, one bit per cycle thereafter (48 consecutive cycles).
REQ-017 sd_cmd_oe SHALL be 1 for exactly the 48 frame cycles and 0 otherwise.
REQ-018 sd_cmd_out SHALL be 1 whenever sd_cmd_oe is 0.
REQ-019 SEND->CRC after the 40th bit; CRC->END after the 7th CRC bit; END->GAP after one cycle.
REQ-020 GAP SHALL last exactly NCC cycles, then return to IDLE; sd_transmit_finished pulses in the first GAP cycle.
REQ-021 busy SHALL rise the cycle after the accepting edge and fall in the first IDLE cycle; it is never high in IDLE.
REQ-022 transmit_en in any state other than IDLE SHALL be ignored (no queuing); transmit_en held high SHALL start a new frame on the first IDLE edge.
REQ-023 The bit counter SHALL be 6 bits and the gap counter 8 bits; neither SHALL wrap within a frame.

Reset
REQ-024 Asserting reset (low) SHALL immediately force IDLE, sd_cmd_out=1, sd_cmd_oe=0, busy=0, both pulses 0, CRC and counters 0.
REQ-025 Reset mid-frame SHALL abort without sd_transmit_finished; after release the block SHALL accept a new request normally.

Structure
REQ-026 A shared package SHALL hold the state encoding, frame length (48), header length (40), CRC width (7), polynomial constant (7'h09), and start/transmission/end bit values.
REQ-027 CRC SHALL be a sub-module crc7_serial (enable, clear, data bit in, 7-bit crc out), reusable by the receive path; shifter and FSM stay in sd_cmd_tx.

Verification
REQ-028 CMD0, arg 0x00000000 -> serial frame 0x400000000095 (CRC 0x4A); oe high 48 cycles; started on start bit; finished one cycle after end bit.
REQ-029 CMD8, arg 0x000001AA -> frame 0x48000001AA87 (CRC 0x43).
REQ-030 CMD17, arg 0x00000000 then CMD55, arg 0x00000000 back-to-back with transmit_en held high -> frames ...55 then ...65; exactly NCC=8 released cycles between end bit and second start bit.
REQ-031 transmit_en pulsed and cmd_index/argument changed during SEND -> current frame unchanged; no second frame issued.
REQ-032 reset asserted at bit 20 of CMD8 -> sd_cmd_oe=0, sd_cmd_out=1 immediately, no finished pulse; after release CMD0 transmits correctly.
REQ-033 NCC=1 build, two commands -> single released cycle between frames; busy low for exactly one IDLE cycle when transmit_en is held.

Source files
------------

// File: rtl/sd_cmd_tx_pkg.sv
// sd_cmd_tx_pkg: shared SD command-line framing constants, state encoding and CRC7 step
package sd_cmd_tx_pkg;
    typedef enum logic [2:0] {IDLE, SEND, CRC, END, GAP} tx_state_t;
    localparam logic [5:0] FRAME_LEN = 6'd48;
    localparam logic [5:0] HDR_LEN = 6'd40;
    localparam int CRC_W = 7;
    localparam logic [6:0] CRC_POLY = 7'h09;
    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT = 1'b1;
    localparam logic END_BIT = 1'b1;
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        return {crc[5:0], 1'b0} ^ ((crc[6] ^ din) ? CRC_POLY : 7'h00);
    endfunction
endpackage

// File: rtl/crc7_serial.sv
// crc7_serial: bit-serial CRC7 (x^7+x^3+1); clear with enable restarts on the given bit
module crc7_serial
    import sd_cmd_tx_pkg::*;
(
    input  logic             sd_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc
);
    always_ff @(posedge sd_clk or negedge reset)
        if (!reset)
            crc <= '0;
        else if (enable)
            crc <= crc7_step(clear ? '0 : crc, data_in);
        else if (clear)
            crc <= '0;
endmodule

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serialises 48-bit SD command frames with on-the-fly CRC7 and an NCC idle gap
module sd_cmd_tx
    import sd_cmd_tx_pkg::*;
#(
    parameter int NCC = 8
) (
    input  logic        sd_clk,
    input  logic        reset,
    input  logic        transmit_en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        sd_transmit_started,
    output logic        sd_transmit_finished
);
    localparam logic [5:0] LAST_CRC = FRAME_LEN - 6'd1;
    localparam logic [7:0] GAP_LAST = 8'(NCC - 1);
    tx_state_t        state;
    logic [39:0]      sreg;
    logic [5:0]       bcnt;
    logic [7:0]       gcnt;
    logic [CRC_W-1:0] crc;
    logic             accept;
    logic             crc_en;
    logic             crc_din;
    assign accept  = state == IDLE && transmit_en;
    assign crc_en  = accept || (state == SEND && bcnt != HDR_LEN);
    assign crc_din = accept ? START_BIT : sreg[39];
    crc7_serial u_crc (
        .sd_clk  (sd_clk),
        .reset   (reset),
        .enable  (crc_en),
        .clear   (accept),
        .data_in (crc_din),
        .crc     (crc)
    );
    // bcnt = frame bits already on the line; the IDLE sampling cycle is the last of the NCC idle cycles
    always_ff @(posedge sd_clk or negedge reset)
        if (!reset) begin
            state                <= IDLE;
            sreg                 <= '0;
            bcnt                 <= '0;
            gcnt                 <= '0;
            sd_cmd_out           <= 1'b1;
            sd_cmd_oe            <= 1'b0;
            busy                 <= 1'b0;
            sd_transmit_started  <= 1'b0;
            sd_transmit_finished <= 1'b0;
        end else begin
            sd_transmit_started  <= accept;
            sd_transmit_finished <= state == END;
            case (state)
                IDLE:
                    if (transmit_en) begin
                        state      <= SEND;
                        sreg       <= {TX_BIT, cmd_index, argument, 1'b0};
                        bcnt       <= 6'd1;
                        sd_cmd_out <= START_BIT;
                        sd_cmd_oe  <= 1'b1;
                        busy       <= 1'b1;
                    end
                SEND: begin
                    bcnt <= bcnt + 6'd1;
                    if (bcnt == HDR_LEN) begin
                        state      <= CRC;
                        sd_cmd_out <= crc[6];
                        sreg       <= {crc[5:0], 34'b0};
                    end else begin
                        sd_cmd_out <= sreg[39];
                        sreg       <= {sreg[38:0], 1'b0};
                    end
                end
                CRC: begin
                    bcnt       <= bcnt + 6'd1;
                    sd_cmd_out <= bcnt == LAST_CRC ? END_BIT : sreg[39];
                    sreg       <= {sreg[38:0], 1'b0};
                    if (bcnt == LAST_CRC)
                        state <= END;
                end
                END: begin
                    state      <= NCC == 1 ? IDLE : GAP;
                    busy       <= NCC != 1;
                    sd_cmd_oe  <= 1'b0;
                    sd_cmd_out <= 1'b1;
                    bcnt       <= '0;
                    gcnt       <= 8'd1;
                end
                GAP: begin
                    gcnt <= gcnt + 8'd1;
                    if (gcnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule
